// File: rtl/uart_ctrl_pkg.sv
// Shared constants and FSM encoding for the UART command controller.
package uart_ctrl_pkg;

  localparam logic [7:0] HDR_REQ = 8'h55;
  localparam logic [7:0] HDR_RSP = 8'hA5;

  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;

  localparam logic [7:0] ST_OK   = 8'h00;
  localparam logic [7:0] ST_CSUM = 8'h01;
  localparam logic [7:0] ST_BAD  = 8'h02;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_CMD  = 4'd1,
    S_ADDR = 4'd2,
    S_DATA = 4'd3,
    S_CSUM = 4'd4,
    S_EXEC = 4'd5,
    S_TX0  = 4'd6,
    S_TX1  = 4'd7,
    S_TX2  = 4'd8
  } state_t;

endpackage

// File: rtl/uart_reg_bank.sv
// NUM_REGS x 8-bit configuration storage with one write port, a read mux
// and the whole bank exposed as a flat bus.
module uart_reg_bank #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [7:0]            i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [7:0]            o_rdata,
  output logic [NUM_REGS*8-1:0] o_reg_bus
);

  logic [7:0] r_regs [NUM_REGS];

  // Storage: cleared on reset, single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read mux; out-of-range addresses read as zero.
  always_comb begin
    if (int'(i_raddr) < NUM_REGS) begin
      o_rdata = r_regs[i_raddr];
    end else begin
      o_rdata = 8'h00;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_bus
    assign o_reg_bus[8*g +: 8] = r_regs[g];
  end

endmodule

// File: rtl/uart_reg_ctrl.sv
// Host command controller: parses 0x55 request frames from the UART receiver,
// executes register reads/writes and sends a 3-byte 0xA5 response.
module uart_reg_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] TIMEOUT_CYC = 32'd2700000,
  parameter logic        CMD_EN_RD   = 1'b1,
  localparam int         ADDR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_req,
  output logic [NUM_REGS*8-1:0] reg_bus,
  output logic                  reg_wr_stb,
  output logic [ADDR_W-1:0]     reg_wr_addr,
  output logic                  busy
);

  localparam logic [8:0] NUM_REGS_W9 = 9'(NUM_REGS);

  state_t              r_state;
  logic [7:0]          r_cmd;
  logic [7:0]          r_addr;
  logic [7:0]          r_data;
  logic [7:0]          r_csum;
  logic [7:0]          r_status;
  logic [7:0]          r_rsp_data;
  logic [7:0]          r_tx_data;
  logic                r_tx_valid;
  logic                r_holdoff;
  logic [31:0]         r_timer;
  logic                r_wr_stb;
  logic [ADDR_W-1:0]   r_wr_addr;

  logic                w_is_wr;
  logic                w_is_rd;
  logic                w_addr_ok;
  logic [7:0]          w_csum_calc;
  logic [7:0]          w_status;
  logic [7:0]          w_rsp_data;
  logic                w_wr_ok;
  logic                w_we;
  logic [7:0]          w_rd_data;
  logic [7:0]          w_tx_byte;
  logic                w_timeout;

  uart_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_we),
    .i_waddr   (r_addr[ADDR_W-1:0]),
    .i_wdata   (r_data),
    .i_raddr   (r_addr[ADDR_W-1:0]),
    .o_rdata   (w_rd_data),
    .o_reg_bus (reg_bus)
  );

  // Execute decision: checksum is judged before command/address validity.
  always_comb begin
    w_is_wr     = (r_cmd == CMD_WR);
    w_is_rd     = (r_cmd == CMD_RD) && CMD_EN_RD;
    w_addr_ok   = ({1'b0, r_addr} < NUM_REGS_W9);
    w_csum_calc = r_cmd + r_addr + (w_is_wr ? r_data : 8'h00);
    w_wr_ok     = 1'b0;
    if (w_csum_calc != r_csum) begin
      w_status   = ST_CSUM;
      w_rsp_data = 8'h00;
    end else if (w_addr_ok && w_is_wr) begin
      w_status   = ST_OK;
      w_rsp_data = r_data;
      w_wr_ok    = 1'b1;
    end else if (w_addr_ok && w_is_rd) begin
      w_status   = ST_OK;
      w_rsp_data = w_rd_data;
    end else begin
      w_status   = ST_BAD;
      w_rsp_data = 8'h00;
    end
    w_we      = (r_state == S_EXEC) && w_wr_ok;
    w_timeout = (r_timer >= (TIMEOUT_CYC - 32'd1));
    case (r_state)
      S_TX0:   w_tx_byte = HDR_RSP;
      S_TX1:   w_tx_byte = r_status;
      S_TX2:   w_tx_byte = r_rsp_data;
      default: w_tx_byte = 8'h00;
    endcase
  end

  // Frame FSM, inter-byte timeout and response sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cmd      <= 8'h00;
      r_addr     <= 8'h00;
      r_data     <= 8'h00;
      r_csum     <= 8'h00;
      r_status   <= 8'h00;
      r_rsp_data <= 8'h00;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_holdoff  <= 1'b0;
      r_timer    <= 32'd0;
      r_wr_stb   <= 1'b0;
      r_wr_addr  <= '0;
    end else begin
      r_tx_valid <= 1'b0;
      r_wr_stb   <= 1'b0;
      if (!tx_req) begin
        r_holdoff <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          r_timer <= 32'd0;
          if (rx_valid && (rx_data == HDR_REQ)) begin
            r_state <= S_CMD;
          end
        end
        S_CMD, S_ADDR, S_DATA, S_CSUM: begin
          // A byte arriving on the expiry cycle still counts.
          if (rx_valid) begin
            r_timer <= 32'd0;
            case (r_state)
              S_CMD: begin
                r_cmd   <= rx_data;
                r_state <= S_ADDR;
              end
              S_ADDR: begin
                r_addr  <= rx_data;
                r_state <= (r_cmd == CMD_WR) ? S_DATA : S_CSUM;
              end
              S_DATA: begin
                r_data  <= rx_data;
                r_state <= S_CSUM;
              end
              default: begin
                r_csum  <= rx_data;
                r_state <= S_EXEC;
              end
            endcase
          end else if (w_timeout) begin
            r_timer <= 32'd0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        S_EXEC: begin
          r_status   <= w_status;
          r_rsp_data <= w_rsp_data;
          if (w_wr_ok) begin
            r_wr_stb  <= 1'b1;
            r_wr_addr <= r_addr[ADDR_W-1:0];
          end
          r_state <= S_TX0;
        end
        S_TX0, S_TX1, S_TX2: begin
          if (tx_req && !r_holdoff) begin
            r_tx_valid <= 1'b1;
            r_holdoff  <= 1'b1;
            r_tx_data  <= w_tx_byte;
            case (r_state)
              S_TX0:   r_state <= S_TX1;
              S_TX1:   r_state <= S_TX2;
              default: r_state <= S_IDLE;
            endcase
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign reg_wr_stb  = r_wr_stb;
  assign reg_wr_addr = r_wr_addr;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: doc/uart_reg_ctrl.md
Name: uart_reg_ctrl

Overview:
Command controller sitting between the UART byte interface (rx_data/rx_valid, tx_data/tx_valid/tx_req) and the video-pipeline configuration registers.
- Parses framed host commands from received bytes, checks them, executes register writes/reads on an internal register bank, then sequences a 3-byte response into the UART transmitter.
- Exposes the register bank as a flat bus that drives edge-detector thresholds and modes.

Parameters:
NUM_REGS, 16, number of 8-bit config registers; ADDR_W = clog2(NUM_REGS) is derived as a localparam
TIMEOUT_CYC, 32'd2700000, inter-byte timeout in clk cycles (100 ms at 27 MHz)
CMD_EN_RD, 1'b1, 1 = read command supported; 0 = read returns status 02

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
rx_data  input  8  received byte, valid with rx_valid
rx_valid  input  1  one-cycle pulse per received byte
tx_data  output  8  byte to transmit
tx_valid  output  1  one-cycle strobe; byte accepted when tx_valid && tx_req
tx_req  input  1  level; high = transmitter can accept a byte
reg_bus  output  NUM_REGS*8  flat register bank; reg i at [8i+7:8i]
reg_wr_stb  output  1  one-cycle pulse after a register write commits
reg_wr_addr  output  ADDR_W  address of last committed write
busy  output  1  high from first header byte until last response byte is accepted

Behaviour:
- Reset (async, rst_n low): all regs = 0x00; tx_data = 0x00; tx_valid, reg_wr_stb, busy = 0; reg_wr_addr = 0; FSM = S_IDLE; timeout counter = 0. Reset asserted mid-frame or mid-response aborts immediately; no partial write.
- Request frame: 0x55, CMD, ADDR, [DATA if CMD=0x01], CSUM. CSUM = (CMD+ADDR+DATA) mod 256 for write, (CMD+ADDR) mod 256 for read.
- Response frame: 0xA5, STATUS, DATA.
  - STATUS 00 = ok, 01 = checksum error, 02 = bad command or ADDR >= NUM_REGS.
  - DATA = written value for a write, register value for a read, 0x00 on error.
- FSM states: S_IDLE -> S_CMD -> S_ADDR -> (S_DATA if CMD=0x01) -> S_CSUM -> S_EXEC -> S_TX0 -> S_TX1 -> S_TX2 -> S_IDLE.
  - Each RX-state transition occurs on rx_valid.
  - S_IDLE ignores every byte other than 0x55.
  - In S_CMD, any value other than 0x01 or 0x02 is accepted; the frame is treated as a read-length frame (no DATA byte), and S_EXEC reports status 02.
- S_EXEC, one cycle:
  - Evaluate checksum first, then command/address validity.
  - On a valid write: update the register; pulse reg_wr_stb in the same cycle the reg_bus change becomes visible; latch reg_wr_addr.
  - Register update latency: 1 clk after the CSUM byte's rx_valid.
- TX handshake:
  - In each S_TXn: drive tx_data and assert tx_valid for exactly one cycle when tx_req = 1 and holdoff = 0.
  - Then wait for tx_req to go low and back high before the next byte. The holdoff flag is set on tx_valid and cleared on tx_req low.
  - tx_data holds its last value between strobes.
- Inter-byte timeout:
  - Counter runs in S_CMD..S_CSUM and clears on every rx_valid.
  - On reaching TIMEOUT_CYC: return to S_IDLE with no response.
  - rx_valid in the same cycle as expiry: the byte wins and the counter clears.
- rx_valid during S_EXEC or S_TXn: byte is dropped, no queueing.
- busy = (FSM != S_IDLE).
- Checksum arithmetic: 8-bit wrap-around add.
- Address compare uses the full 8-bit ADDR against NUM_REGS.

Decomposition:
- Package uart_ctrl_pkg holds:
  - header constants: HDR_REQ=8'h55, HDR_RSP=8'hA5
  - command codes: CMD_WR=8'h01, CMD_RD=8'h02
  - status codes: ST_OK=8'h00, ST_CSUM=8'h01, ST_BAD=8'h02
  - FSM state encoding
- One sub-module, uart_reg_bank: NUM_REGS x 8 storage, async-reset to 0, single write port, combinational read mux, flat reg_bus output.
- Frame FSM, checksum and TX sequencing stay in uart_reg_ctrl.

Test Plan:
- Write: rx 55 01 03 7F 83 -> reg_bus[31:24]=0x7F one clk after last byte; reg_wr_stb single pulse with reg_wr_addr=3; tx A5 00 7F; busy low afterwards.
- Read-back: after the write, rx 55 02 03 05 -> tx A5 00 7F; no reg_wr_stb.
- Bad checksum: rx 55 01 02 10 00 -> tx A5 01 00; reg 2 stays 0x00; no reg_wr_stb. Bad address (NUM_REGS=16): rx 55 02 14 16 -> tx A5 02 00.
- Framing/timeout: rx 12 34 55 01 then silence > TIMEOUT_CYC -> no tx, FSM back to S_IDLE; a following valid write frame executes normally.
- TX flow control: hold tx_req low 500 cycles during a response -> tx_valid stays 0 until tx_req rises; exactly 3 strobes total. Bytes injected during TX are dropped, with no extra response.
- Reset mid-frame: assert rst_n low after 55 01 05 -> all outputs at reset values, no write to reg 5; the next full frame works.
